// File: rtl/stream_packer_if.sv
// stream_packer_if: narrow-in / wide-out valid-ready bundle for stream_packer.
// in_last and out_keep exist only when STREAM_PACKER_PACK_LAST_EN is defined.
interface stream_packer_if #(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
);
  logic in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH*RATIO-1:0] data_out;
`ifdef STREAM_PACKER_PACK_LAST_EN
  logic in_last;
  logic [RATIO-1:0] out_keep;
  modport slave(input in_valid, data_in, in_last, out_ready, output in_ready, out_valid, data_out, out_keep);
  modport master(output in_valid, data_in, in_last, out_ready, input in_ready, out_valid, data_out, out_keep);
`else
  modport slave(input in_valid, data_in, out_ready, output in_ready, out_valid, data_out);
  modport master(output in_valid, data_in, out_ready, input in_ready, out_valid, data_out);
`endif
endinterface

// File: rtl/stream_packer.sv
// stream_packer: packs RATIO WIDTH-bit beats little-endian into one wide word, valid/ready on both sides.
// Define STREAM_PACKER_PACK_LAST_EN for in_last early close with zero upper lanes and out_keep.
module stream_packer #(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
) (
  input logic clk,
  input logic rst,
  stream_packer_if.slave s
);
  localparam int CW = $clog2(RATIO);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RATIO-2:0][WIDTH-1:0] acc_q, acc_d;
  logic [RATIO-1:0][WIDTH-1:0] ext, word, data_q, data_d;
  logic out_valid_q, out_valid_d, closing, accept;
`ifdef STREAM_PACKER_PACK_LAST_EN
  logic [RATIO-1:0] keep, keep_q, keep_d;
  assign closing = cnt_q == CW'(RATIO - 1) || s.in_last;
  assign s.out_keep = keep_q;
`else
  assign closing = cnt_q == CW'(RATIO - 1);
`endif
  assign accept = s.in_valid && s.in_ready;
  assign s.in_ready = !out_valid_q || s.out_ready || !closing;
  assign s.out_valid = out_valid_q;
  assign s.data_out = data_q;
  assign ext = {s.data_in, acc_q};
  // The closing beat lands in lane cnt; lanes above it are reachable only via in_last and read as zero.
  always_comb begin
    for (int k = 0; k < RATIO; k++) begin
      word[k] = CW'(k) == cnt_q ? s.data_in : CW'(k) < cnt_q ? ext[k] : '0;
`ifdef STREAM_PACKER_PACK_LAST_EN
      keep[k] = CW'(k) <= cnt_q;
`endif
    end
  end
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    data_d = data_q;
    out_valid_d = out_valid_q && !s.out_ready;
`ifdef STREAM_PACKER_PACK_LAST_EN
    keep_d = keep_q;
`endif
    if (accept && !closing) begin
      acc_d[cnt_q] = s.data_in;
      cnt_d = cnt_q + 1'b1;
    end
    if (accept && closing) begin
      data_d = word;
      out_valid_d = 1'b1;
      cnt_d = '0;
`ifdef STREAM_PACKER_PACK_LAST_EN
      keep_d = keep;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      acc_q <= '0;
      data_q <= '0;
      out_valid_q <= 1'b0;
`ifdef STREAM_PACKER_PACK_LAST_EN
      keep_q <= '0;
`endif
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      data_q <= data_d;
      out_valid_q <= out_valid_d;
`ifdef STREAM_PACKER_PACK_LAST_EN
      keep_q <= keep_d;
`endif
    end
  end
endmodule

// File: tb/tb_stream_packer.sv
// tb_stream_packer: directed vector table for stream_packer at WIDTH=8, RATIO=4.
module tb_stream_packer;
  typedef struct {
    logic r, iv, ordy, last, e_rdy, e_ov;
    logic [7:0] din;
    logic [31:0] e_do;
    logic [3:0] e_keep;
  } vec_t;
  vec_t vq[$];
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  stream_packer_if #(.WIDTH(8), .RATIO(4)) bus();
  stream_packer #(.WIDTH(8), .RATIO(4)) dut (.clk(clk), .rst(rst), .s(bus));
  task automatic add(input logic r, input logic iv, input logic [7:0] d, input logic ordy, input logic last,
                     input logic e_rdy, input logic e_ov, input logic [31:0] e_do, input logic [3:0] e_keep);
    vec_t v;
    v.r = r; v.iv = iv; v.din = d; v.ordy = ordy; v.last = last;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_do = e_do; v.e_keep = e_keep;
    vq.push_back(v);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.data_in = '0;
    bus.out_ready = 1'b0;
`ifdef STREAM_PACKER_PACK_LAST_EN
    bus.in_last = 1'b0;
`endif
    // steady stream 11..44 then back-to-back 01..08
    add(0,1,8'h11,1,0, 1,0,32'h0,4'h0);
    add(0,1,8'h22,1,0, 1,0,32'h0,4'h0);
    add(0,1,8'h33,1,0, 1,0,32'h0,4'h0);
    add(0,1,8'h44,1,0, 1,0,32'h0,4'h0);
    add(0,1,8'h01,1,0, 1,1,32'h44332211,4'hF);
    add(0,1,8'h02,1,0, 1,0,32'h44332211,4'hF);
    add(0,1,8'h03,1,0, 1,0,32'h44332211,4'hF);
    add(0,1,8'h04,1,0, 1,0,32'h44332211,4'hF);
    add(0,1,8'h05,1,0, 1,1,32'h04030201,4'hF);
    add(0,1,8'h06,1,0, 1,0,32'h04030201,4'hF);
    add(0,1,8'h07,1,0, 1,0,32'h04030201,4'hF);
    add(0,1,8'h08,1,0, 1,0,32'h04030201,4'hF);
    add(0,0,8'h00,1,0, 1,1,32'h08070605,4'hF);
    // output stall, then simultaneous drain and load
    add(0,1,8'h01,0,0, 1,0,32'h08070605,4'hF);
    add(0,1,8'h02,0,0, 1,0,32'h08070605,4'hF);
    add(0,1,8'h03,0,0, 1,0,32'h08070605,4'hF);
    add(0,1,8'h04,0,0, 1,0,32'h08070605,4'hF);
    add(0,1,8'h05,0,0, 1,1,32'h04030201,4'hF);
    add(0,1,8'h06,0,0, 1,1,32'h04030201,4'hF);
    add(0,1,8'h07,0,0, 1,1,32'h04030201,4'hF);
    add(0,1,8'h08,0,0, 0,1,32'h04030201,4'hF);
    add(0,1,8'h08,0,0, 0,1,32'h04030201,4'hF);
    add(0,1,8'h08,1,0, 1,1,32'h04030201,4'hF);
    add(0,0,8'h00,0,0, 1,1,32'h08070605,4'hF);
    add(0,0,8'h00,1,0, 1,1,32'h08070605,4'hF);
    // reset mid-word discards AA, BB
    add(0,1,8'hAA,1,0, 1,0,32'h08070605,4'hF);
    add(0,1,8'hBB,1,0, 1,0,32'h08070605,4'hF);
    add(1,0,8'h00,1,0, 1,0,32'h08070605,4'hF);
    add(0,1,8'h01,1,0, 1,0,32'h0,4'h0);
    add(0,1,8'h02,1,0, 1,0,32'h0,4'h0);
    add(0,1,8'h03,1,0, 1,0,32'h0,4'h0);
    add(0,1,8'h04,1,0, 1,0,32'h0,4'h0);
    add(0,0,8'h00,1,0, 1,1,32'h04030201,4'hF);
    // in_valid gaps
    add(0,1,8'h10,1,0, 1,0,32'h04030201,4'hF);
    add(0,0,8'h99,1,0, 1,0,32'h04030201,4'hF);
    add(0,1,8'h20,1,0, 1,0,32'h04030201,4'hF);
    add(0,0,8'h99,1,0, 1,0,32'h04030201,4'hF);
    add(0,0,8'h99,1,0, 1,0,32'h04030201,4'hF);
    add(0,1,8'h30,1,0, 1,0,32'h04030201,4'hF);
    add(0,0,8'h99,1,0, 1,0,32'h04030201,4'hF);
    add(0,1,8'h40,1,0, 1,0,32'h04030201,4'hF);
    add(0,0,8'h00,1,0, 1,1,32'h40302010,4'hF);
    add(0,0,8'h00,1,0, 1,0,32'h40302010,4'hF);
`ifdef STREAM_PACKER_PACK_LAST_EN
    // early close on in_last, then a full word
    add(0,1,8'h11,1,0, 1,0,32'h40302010,4'hF);
    add(0,1,8'h22,1,1, 1,0,32'h40302010,4'hF);
    add(0,1,8'h33,1,0, 1,1,32'h00002211,4'h3);
    add(0,1,8'h44,1,0, 1,0,32'h00002211,4'h3);
    add(0,1,8'h55,1,0, 1,0,32'h00002211,4'h3);
    add(0,1,8'h66,1,0, 1,0,32'h00002211,4'h3);
    add(0,0,8'h00,1,0, 1,1,32'h66554433,4'hF);
`endif
    repeat (3) @(negedge clk);
    #1;
    chk("reset out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("reset data_out", bus.data_out, 32'h0);
`ifdef STREAM_PACKER_PACK_LAST_EN
    chk("reset out_keep", {28'b0, bus.out_keep}, 32'h0);
`endif
    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].r;
      bus.in_valid = vq[i].iv;
      bus.data_in = vq[i].din;
      bus.out_ready = vq[i].ordy;
`ifdef STREAM_PACKER_PACK_LAST_EN
      bus.in_last = vq[i].last;
`endif
      #1;
      chk($sformatf("row%0d in_ready", i), {31'b0, bus.in_ready}, {31'b0, vq[i].e_rdy});
      chk($sformatf("row%0d out_valid", i), {31'b0, bus.out_valid}, {31'b0, vq[i].e_ov});
      chk($sformatf("row%0d data_out", i), bus.data_out, vq[i].e_do);
`ifdef STREAM_PACKER_PACK_LAST_EN
      chk($sformatf("row%0d out_keep", i), {28'b0, bus.out_keep}, {28'b0, vq[i].e_keep});
`endif
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
